// File: rtl/writeback_arbiter.sv
// writeback_arbiter: per-source result FIFOs arbitrated onto one registered
// register-file write port, with a combinational pending-write scoreboard.
// Build option: define WB_RR_ARB_EN for round-robin arbitration; otherwise the
// lowest-indexed non-empty source wins (fixed priority).
//
// Handshake: a push on source k completes when src_valid_i[k] && src_ready_o[k]
// at a rising edge. src_ready_o[k] depends only on registered FIFO occupancy,
// never on same-cycle valid or pop. A push to rd==0 completes but stores nothing.
module writeback_arbiter #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 4,
    parameter int DEPTH   = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NUM_SRC-1:0]                     src_valid_i,
    output logic [NUM_SRC-1:0]                     src_ready_o,
    input  logic [NUM_SRC-1:0][4:0]                src_rd_i,
    input  logic [NUM_SRC-1:0][XLEN-1:0]           src_data_i,
    input  logic                                   flush_i,
    input  logic                                   stall_i,
    output logic                                   rf_we_o,
    output logic [4:0]                             rf_waddr_o,
    output logic [XLEN-1:0]                        rf_wdata_o,
    input  logic [1:0][4:0]                        query_rs_i,
    output logic [1:0]                             query_hit_o,
    output logic [$clog2(NUM_SRC*DEPTH+1)-1:0]     pending_cnt_o
);

    localparam int PW   = $clog2(DEPTH);
    localparam int PTRW = PW + 1;
    localparam int SW   = $clog2(NUM_SRC);
    localparam int CNTW = $clog2(NUM_SRC*DEPTH+1);

    logic [4:0]      rd_mem   [NUM_SRC][DEPTH];
    logic [XLEN-1:0] data_mem [NUM_SRC][DEPTH];
    logic [PTRW-1:0] wr_ptr   [NUM_SRC];
    logic [PTRW-1:0] rd_ptr   [NUM_SRC];

    logic [NUM_SRC-1:0] empty;
    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] push;
    logic [CNTW-1:0]    push_cnt;

    logic               grant_found;
    logic [SW-1:0]      grant_idx;
    logic [SW-1:0]      cand;
    int                 arb_idx;

    logic [PTRW-1:0]    occ;
    logic [PW-1:0]      off;

`ifdef WB_RR_ARB_EN
    logic [SW-1:0]      rr_q;
`endif

    // FIFO status and accepted pushes; the wrap bit separates full from empty.
    always_comb begin
        push_cnt = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            empty[k]       = (wr_ptr[k] == rd_ptr[k]);
            full[k]        = (wr_ptr[k][PW] != rd_ptr[k][PW]) &&
                             (wr_ptr[k][PW-1:0] == rd_ptr[k][PW-1:0]);
            src_ready_o[k] = !full[k];
            push[k]        = src_valid_i[k] && !full[k] && (src_rd_i[k] != 5'd0) && !flush_i;
            push_cnt       = push_cnt + CNTW'(push[k]);
        end
    end

    // Pick one non-empty source to retire, starting the search at rr_q or at 0.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        arb_idx     = 0;
        if (!stall_i && !flush_i) begin
            for (int i = 0; i < NUM_SRC; i++) begin
`ifdef WB_RR_ARB_EN
                arb_idx = (int'(rr_q) + i) % NUM_SRC;
`else
                arb_idx = i;
`endif
                cand = SW'(arb_idx);
                if (!grant_found && !empty[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    // Pointer update; flush and reset both empty every FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (push[k])
                    wr_ptr[k] <= wr_ptr[k] + PTRW'(1);
                if (grant_found && (grant_idx == SW'(k)))
                    rd_ptr[k] <= rd_ptr[k] + PTRW'(1);
            end
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NUM_SRC; k++) begin
            if (push[k]) begin
                rd_mem[k][wr_ptr[k][PW-1:0]]   <= src_rd_i[k];
                data_mem[k][wr_ptr[k][PW-1:0]] <= src_data_i[k];
            end
        end
    end

    // Registered write port: one cycle of rf_we_o per retired entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
        end else if (grant_found) begin
            rf_we_o    <= 1'b1;
            rf_waddr_o <= rd_mem[grant_idx][rd_ptr[grant_idx][PW-1:0]];
            rf_wdata_o <= data_mem[grant_idx][rd_ptr[grant_idx][PW-1:0]];
        end else begin
            rf_we_o    <= 1'b0;
        end
    end

    // Queued-entry count, excluding the staged write.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i)
            pending_cnt_o <= '0;
        else
            pending_cnt_o <= pending_cnt_o + push_cnt - CNTW'(grant_found);
    end

`ifdef WB_RR_ARB_EN
    // Round-robin pointer moves past the last winner; holds when idle or flushed.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            rr_q <= '0;
        else if (grant_found)
            rr_q <= (grant_idx == SW'(NUM_SRC-1)) ? '0 : grant_idx + SW'(1);
    end
`endif

    // Scoreboard: rsN hits any occupied FIFO slot or the staged write; x0 never hits.
    always_comb begin
        query_hit_o = '0;
        occ         = '0;
        off         = '0;
        for (int q = 0; q < 2; q++) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                occ = wr_ptr[k] - rd_ptr[k];
                for (int j = 0; j < DEPTH; j++) begin
                    off = PW'(j) - rd_ptr[k][PW-1:0];
                    if ((PTRW'(off) < occ) && (rd_mem[k][j] == query_rs_i[q]))
                        query_hit_o[q] = 1'b1;
                end
            end
            if (rf_we_o && (rf_waddr_o == query_rs_i[q]))
                query_hit_o[q] = 1'b1;
            if (query_rs_i[q] == 5'd0)
                query_hit_o[q] = 1'b0;
        end
    end

endmodule
